// File: rtl/gcm_pkg.sv
// rtl/gcm_pkg.sv - shared types, codes and widths for the GCM stream packer
// Purpose: block-type codes, FSM state encodings, datapath widths and the
//          byte-masking helper shared by gcm_stream_packer and gcm_word_packer.
// Ports:   none (package).
package gcm_pkg;

  localparam int BLOCK_W = 128;
  localparam int WORD_W  = 32;

  typedef enum logic [1:0] {
    BT_AAD     = 2'b00,
    BT_PAYLOAD = 2'b01,
    BT_LEN     = 2'b10
  } blk_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AAD  = 2'd1,
    ST_DATA = 2'd2,
    ST_LEN  = 2'd3
  } state_e;

  // Keep the first n bytes of a word (byte 0 sits at bits [0:7]); zero the rest.
  function automatic logic [0:WORD_W-1] mask_word(input logic [0:WORD_W-1] w,
                                                  input logic [2:0] n);
    logic [0:WORD_W-1] r;
    r = '0;
    for (int b = 0; b < 4; b++) begin
      if (3'(b) < n) r[8*b +: 8] = w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/gcm_word_packer.sv
// rtl/gcm_word_packer.sv - accumulates 32-bit words into zero-padded 128-bit blocks
// Purpose: holds the partial block and word index; presents the completed
//          block combinationally in the cycle of the word that closes it.
// Ports:   iClk/iRstn clock and sync active-low reset; iClear drops the partial
//          block; iPush/iWord/iBytes/iLast a validated word; oFlush the pushed word
//          closes a block; oData/oBytes the block and its byte count;
//          oEmpty no bytes held.
module gcm_word_packer import gcm_pkg::*; (
  input  logic                iClk,
  input  logic                iRstn,
  input  logic                iClear,
  input  logic                iPush,
  input  logic [0:WORD_W-1]   iWord,
  input  logic [2:0]          iBytes,
  input  logic                iLast,
  output logic                oFlush,
  output logic [0:BLOCK_W-1]  oData,
  output logic [4:0]          oBytes,
  output logic                oEmpty
);

  logic [0:BLOCK_W-1] acc_q;
  logic [1:0]         idx_q;
  logic [0:WORD_W-1]  masked;

  always_comb begin
    masked = mask_word(iWord, iBytes);
    oData  = acc_q;
    for (int k = 0; k < 4; k++) begin
      if (idx_q == 2'(k)) oData[WORD_W*k +: WORD_W] = masked;
    end
  end

  // Only the final word of a block may be short, so earlier slots are always full.
  assign oBytes = {1'b0, idx_q, 2'b00} + {2'b00, iBytes};
  assign oEmpty = (idx_q == 2'd0);
  assign oFlush = iPush && ((idx_q == 2'd3) ||
                            (iLast && ((idx_q != 2'd0) || (iBytes != 3'd0))));

  always_ff @(posedge iClk) begin
    if (!iRstn || iClear) begin
      acc_q <= '0;
      idx_q <= 2'd0;
    end else if (iPush) begin
      // A last word either closes a block or is an empty tail; both restart.
      if (oFlush || iLast) begin
        acc_q <= '0;
        idx_q <= 2'd0;
      end else begin
        acc_q <= oData;
        idx_q <= idx_q + 2'd1;
      end
    end
  end

endmodule

// File: rtl/gcm_stream_packer.sv
// rtl/gcm_stream_packer.sv - packs AAD/payload word streams into GCM blocks plus length block
// Purpose: message FSM (IDLE/AAD/DATA/LEN), 32-bit byte counters, protocol error
//          detection and the registered block output stage.
// Ports:   iClk/iRstn clock and sync active-low reset; iStart begins/aborts a message;
//          iWord* word input with oWord_ready handshake; oBlock* block output with
//          oBlock_valid/iBlock_ready handshake; oDone end-of-message pulse;
//          oErr sticky protocol error.
module gcm_stream_packer import gcm_pkg::*; (
  input  logic                iClk,
  input  logic                iRstn,
  input  logic                iStart,
  input  logic [0:WORD_W-1]   iWord,
  input  logic                iWord_valid,
  input  logic                iWord_type,
  input  logic [2:0]          iWord_bytes,
  input  logic                iWord_last,
  output logic                oWord_ready,
  output logic [0:BLOCK_W-1]  oBlock,
  output logic [1:0]          oBlock_type,
  output logic [4:0]          oBlock_bytes,
  output logic                oBlock_last,
  output logic                oBlock_valid,
  input  logic                iBlock_ready,
  output logic                oDone,
  output logic                oErr
);

  state_e             state_q;
  logic [31:0]        aad_cnt_q, pay_cnt_q;
  logic               len_sent_q;
  logic               accept, word_err, type_bad, push;
  logic [32:0]        cnt_sum;
  logic               pk_flush, pk_empty;
  logic [0:BLOCK_W-1] pk_data;
  logic [4:0]         pk_bytes;

  // Ready depends only on registers, never on iBlock_ready.
  assign oWord_ready = ((state_q == ST_AAD) || (state_q == ST_DATA)) && !oBlock_valid;
  assign accept      = iWord_valid && oWord_ready && !iStart;
  assign type_bad    = (state_q == ST_AAD) ? iWord_type : !iWord_type;
  assign word_err    = (iWord_bytes > 3'd4) ||
                       ((iWord_bytes < 3'd4) && !iWord_last) ||
                       ((iWord_bytes == 3'd0) && !pk_empty) ||
                       type_bad;
  assign push        = accept && !word_err;
  assign cnt_sum     = {1'b0, (state_q == ST_AAD) ? aad_cnt_q : pay_cnt_q} +
                       {30'd0, iWord_bytes};

  gcm_word_packer u_packer (
    .iClk   (iClk),
    .iRstn  (iRstn),
    .iClear (iStart),
    .iPush  (push),
    .iWord  (iWord),
    .iBytes (iWord_bytes),
    .iLast  (iWord_last),
    .oFlush (pk_flush),
    .oData  (pk_data),
    .oBytes (pk_bytes),
    .oEmpty (pk_empty)
  );

  always_ff @(posedge iClk) begin
    if (!iRstn) begin
      state_q      <= ST_IDLE;
      aad_cnt_q    <= '0;
      pay_cnt_q    <= '0;
      len_sent_q   <= 1'b0;
      oBlock       <= '0;
      oBlock_type  <= BT_AAD;
      oBlock_bytes <= '0;
      oBlock_last  <= 1'b0;
      oBlock_valid <= 1'b0;
      oDone        <= 1'b0;
      oErr         <= 1'b0;
    end else begin
      oDone <= 1'b0;
      if (iStart) begin
        // Start from any state: drop partial data and any pending block.
        state_q      <= ST_AAD;
        aad_cnt_q    <= '0;
        pay_cnt_q    <= '0;
        len_sent_q   <= 1'b0;
        oBlock       <= '0;
        oBlock_type  <= BT_AAD;
        oBlock_bytes <= '0;
        oBlock_last  <= 1'b0;
        oBlock_valid <= 1'b0;
        oErr         <= 1'b0;
      end else begin
        if (oBlock_valid && iBlock_ready) begin
          oBlock_valid <= 1'b0;
          if (state_q == ST_LEN && len_sent_q) begin
            state_q    <= ST_IDLE;
            len_sent_q <= 1'b0;
            oDone      <= 1'b1;
          end
        end

        if (accept && word_err) oErr <= 1'b1;

        // push implies the output register is free, so no clash with the drain above.
        if (push) begin
          if (state_q == ST_AAD) aad_cnt_q <= cnt_sum[31:0];
          else                   pay_cnt_q <= cnt_sum[31:0];
          if (cnt_sum[32]) oErr <= 1'b1;
          if (pk_flush) begin
            oBlock       <= pk_data;
            oBlock_type  <= (state_q == ST_AAD) ? BT_AAD : BT_PAYLOAD;
            oBlock_bytes <= pk_bytes;
            oBlock_last  <= iWord_last;
            oBlock_valid <= 1'b1;
          end
          if (iWord_last) state_q <= (state_q == ST_AAD) ? ST_DATA : ST_LEN;
        end

        // Length block waits for the last payload block (if any) to drain.
        if (state_q == ST_LEN && !len_sent_q && !oBlock_valid) begin
          oBlock       <= {29'd0, aad_cnt_q, 3'd0, 29'd0, pay_cnt_q, 3'd0};
          oBlock_type  <= BT_LEN;
          oBlock_bytes <= 5'd16;
          oBlock_last  <= 1'b1;
          oBlock_valid <= 1'b1;
          len_sent_q   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gcm_stream_packer.sv
// tb/tb_gcm_stream_packer.sv - self-checking bench for gcm_stream_packer
module tb_gcm_stream_packer;

  logic         iClk, iRstn, iStart;
  logic [0:31]  iWord;
  logic         iWord_valid, iWord_type, iWord_last;
  logic [2:0]   iWord_bytes;
  logic         oWord_ready;
  logic [0:127] oBlock;
  logic [1:0]   oBlock_type;
  logic [4:0]   oBlock_bytes;
  logic         oBlock_last, oBlock_valid, iBlock_ready, oDone, oErr;

  gcm_stream_packer dut (
    .iClk(iClk), .iRstn(iRstn), .iStart(iStart),
    .iWord(iWord), .iWord_valid(iWord_valid), .iWord_type(iWord_type),
    .iWord_bytes(iWord_bytes), .iWord_last(iWord_last), .oWord_ready(oWord_ready),
    .oBlock(oBlock), .oBlock_type(oBlock_type), .oBlock_bytes(oBlock_bytes),
    .oBlock_last(oBlock_last), .oBlock_valid(oBlock_valid), .iBlock_ready(iBlock_ready),
    .oDone(oDone), .oErr(oErr)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  typedef struct { logic [0:127] data; logic [1:0] typ; logic [4:0] bytes; logic last; } blk_t;
  typedef struct { logic [0:31] w; logic t; logic [2:0] n; logic l; } wrd_t;
  typedef struct { logic [31:0] w; logic t; logic [2:0] n; logic l; logic err; logic [127:0] data; } vec_t;

  blk_t       got_q[$], exp_q[$];
  wrd_t       wq[$];
  logic [7:0] seg[$];
  vec_t       tbl[7];
  int         pass_cnt = 0, total_cnt = 0;
  int         done_cnt = 0, done_base = 0;
  int         rdy_mode = 1;

  // Block sink: drives iBlock_ready at the falling edge and logs the transfer
  // that will happen at the next rising edge.
  always @(negedge iClk) begin
    case (rdy_mode)
      0:       iBlock_ready = 1'b0;
      1:       iBlock_ready = 1'b1;
      default: iBlock_ready = ($urandom_range(0, 3) != 0);
    endcase
    if (oBlock_valid && iBlock_ready) got_q.push_back('{oBlock, oBlock_type, oBlock_bytes, oBlock_last});
    if (oDone) done_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  function automatic logic [135:0] pk(input blk_t b);
    return {b.data, b.typ, b.bytes, b.last};
  endfunction

  task automatic exp_blk(input logic [127:0] d, input logic [1:0] t, input logic [4:0] n, input logic l);
    exp_q.push_back('{d, t, n, l});
  endtask

  task automatic start_msg();
    got_q.delete();
    exp_q.delete();
    iWord_valid = 1'b0;
    iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    done_base = done_cnt;
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_word(input logic [0:31] w, input logic t, input logic [2:0] n, input logic l);
    int k = 0;
    iWord = w; iWord_type = t; iWord_bytes = n; iWord_last = l; iWord_valid = 1'b1;
    while (!oWord_ready && k < 300) begin @(negedge iClk); k++; end
    if (!oWord_ready) chk("send_timeout", 0, 1);
    @(negedge iClk);
    iWord_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (done_cnt == done_base && k < 500) begin @(negedge iClk); k++; end
    repeat (2) @(negedge iClk);
    chk({tag, "_done_once"}, done_cnt - done_base, 1);
  endtask

  task automatic compare_blocks(input string tag);
    chk({tag, "_nblocks"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) chk($sformatf("%s_blk%0d", tag, i), pk(got_q[i]), pk(exp_q[i]));
  endtask

  // Reference model: a segment's bytes cut into 16-byte blocks, zero padded.
  task automatic model_seg(input logic [1:0] t);
    int n, off, c;
    blk_t b;
    n = seg.size();
    off = 0;
    while (off < n) begin
      c = (n - off > 16) ? 16 : n - off;
      b.data = '0;
      for (int i = 0; i < c; i++) b.data[8*i +: 8] = seg[off + i];
      b.typ = t; b.bytes = 5'(c); b.last = (off + c == n);
      exp_q.push_back(b);
      off += c;
    end
  endtask

  task automatic gen_seg(input logic t, output int nbytes);
    int nw;
    logic [0:31] w;
    logic [2:0] n;
    seg.delete();
    nw = $urandom_range(0, 6);
    if (nw == 0) wq.push_back('{32'($urandom), t, 3'd0, 1'b1});
    for (int i = 0; i < nw; i++) begin
      w = $urandom;
      n = (i == nw - 1) ? 3'($urandom_range(1, 4)) : 3'd4;
      wq.push_back('{w, t, n, (i == nw - 1)});
      for (int b = 0; b < 4; b++) if (3'(b) < n) seg.push_back(w[8*b +: 8]);
    end
    nbytes = seg.size();
    model_seg(t ? 2'b01 : 2'b00);
  endtask

  logic [135:0] snap;
  logic         stable_ok;
  int           la, lp;

  initial begin
    tbl[0] = '{32'hAABBCCDD, 1'b0, 3'd1, 1'b1, 1'b0, {32'hAA000000, 96'h0}};
    tbl[1] = '{32'hAABBCCDD, 1'b0, 3'd2, 1'b1, 1'b0, {32'hAABB0000, 96'h0}};
    tbl[2] = '{32'hAABBCCDD, 1'b0, 3'd3, 1'b1, 1'b0, {32'hAABBCC00, 96'h0}};
    tbl[3] = '{32'hAABBCCDD, 1'b0, 3'd4, 1'b1, 1'b0, {32'hAABBCCDD, 96'h0}};
    tbl[4] = '{32'h11223344, 1'b0, 3'd3, 1'b0, 1'b1, 128'h0};
    tbl[5] = '{32'h11223344, 1'b0, 3'd5, 1'b1, 1'b1, 128'h0};
    tbl[6] = '{32'h11223344, 1'b1, 3'd4, 1'b1, 1'b1, 128'h0};

    iRstn = 1'b0; iStart = 1'b0; iWord = '0; iWord_valid = 1'b0;
    iWord_type = 1'b0; iWord_bytes = 3'd0; iWord_last = 1'b0;
    repeat (3) @(negedge iClk);
    chk("reset_ctrl", {oBlock_valid, oWord_ready, oDone, oErr}, 4'b0000);
    chk("reset_block", {oBlock, oBlock_type, oBlock_bytes, oBlock_last}, 136'h0);
    iRstn = 1'b1;
    @(negedge iClk);

    // Four full AAD words, empty payload.
    start_msg();
    send_word(32'h00010203, 1'b0, 3'd4, 1'b0);
    send_word(32'h04050607, 1'b0, 3'd4, 1'b0);
    send_word(32'h08090A0B, 1'b0, 3'd4, 1'b0);
    send_word(32'h0C0D0E0F, 1'b0, 3'd4, 1'b1);
    send_word(32'h0, 1'b1, 3'd0, 1'b1);
    wait_done("aad4");
    exp_blk(128'h000102030405060708090A0B0C0D0E0F, 2'b00, 5'd16, 1'b1);
    exp_blk({64'h80, 64'h0}, 2'b10, 5'd16, 1'b1);
    compare_blocks("aad4");

    // Five payload words, last one carries two bytes.
    start_msg();
    send_word(32'h0, 1'b0, 3'd0, 1'b1);
    send_word(32'h10111213, 1'b1, 3'd4, 1'b0);
    send_word(32'h14151617, 1'b1, 3'd4, 1'b0);
    send_word(32'h18191A1B, 1'b1, 3'd4, 1'b0);
    send_word(32'h1C1D1E1F, 1'b1, 3'd4, 1'b0);
    send_word(32'hAABBCCDD, 1'b1, 3'd2, 1'b1);
    wait_done("pay5");
    exp_blk(128'h101112131415161718191A1B1C1D1E1F, 2'b01, 5'd16, 1'b0);
    exp_blk({32'hAABB0000, 96'h0}, 2'b01, 5'd2, 1'b1);
    exp_blk({64'h0, 64'h90}, 2'b10, 5'd16, 1'b1);
    compare_blocks("pay5");

    // Backpressure: block held for 10 cycles while a payload word waits.
    rdy_mode = 0;
    start_msg();
    send_word(32'h00010203, 1'b0, 3'd4, 1'b0);
    send_word(32'h04050607, 1'b0, 3'd4, 1'b0);
    send_word(32'h08090A0B, 1'b0, 3'd4, 1'b0);
    send_word(32'h0C0D0E0F, 1'b0, 3'd4, 1'b1);
    iWord = 32'h55667788; iWord_type = 1'b1; iWord_bytes = 3'd4; iWord_last = 1'b1; iWord_valid = 1'b1;
    snap = {oBlock, oBlock_type, oBlock_bytes, oBlock_last};
    stable_ok = oBlock_valid;
    repeat (10) begin
      @(negedge iClk);
      if ({oBlock, oBlock_type, oBlock_bytes, oBlock_last} !== snap || oWord_ready || !oBlock_valid) stable_ok = 1'b0;
    end
    chk("stall_stable", stable_ok, 1'b1);
    rdy_mode = 1;
    send_word(32'h55667788, 1'b1, 3'd4, 1'b1);
    wait_done("stall");
    exp_blk(128'h000102030405060708090A0B0C0D0E0F, 2'b00, 5'd16, 1'b1);
    exp_blk({32'h55667788, 96'h0}, 2'b01, 5'd4, 1'b1);
    exp_blk({64'h80, 64'h20}, 2'b10, 5'd16, 1'b1);
    compare_blocks("stall");

    // Empty AAD and empty payload.
    start_msg();
    send_word(32'hFFFFFFFF, 1'b0, 3'd0, 1'b1);
    send_word(32'hFFFFFFFF, 1'b1, 3'd0, 1'b1);
    wait_done("empty");
    exp_blk(128'h0, 2'b10, 5'd16, 1'b1);
    compare_blocks("empty");

    // Abort after two payload words, then a clean message.
    start_msg();
    send_word(32'h0, 1'b0, 3'd0, 1'b1);
    send_word(32'h01020304, 1'b1, 3'd4, 1'b0);
    send_word(32'h05060708, 1'b1, 3'd4, 1'b0);
    start_msg();
    repeat (5) @(negedge iClk);
    chk("abort_noblk", got_q.size(), 0);
    chk("abort_nodone", done_cnt - done_base, 0);
    chk("abort_err", oErr, 1'b0);
    send_word(32'hDEADBEEF, 1'b0, 3'd4, 1'b1);
    send_word(32'h0, 1'b1, 3'd0, 1'b1);
    wait_done("after_abort");
    exp_blk({32'hDEADBEEF, 96'h0}, 2'b00, 5'd4, 1'b1);
    exp_blk({64'h20, 64'h0}, 2'b10, 5'd16, 1'b1);
    compare_blocks("after_abort");

    // Short word without last: sticky error until the next start.
    start_msg();
    send_word(32'h11223344, 1'b0, 3'd3, 1'b0);
    repeat (2) @(negedge iClk);
    chk("err_set", oErr, 1'b1);
    send_word(32'h55667788, 1'b0, 3'd4, 1'b1);
    repeat (5) @(negedge iClk);
    chk("err_sticky", oErr, 1'b1);
    start_msg();
    chk("err_cleared", oErr, 1'b0);

    // Reset in mid-message drops everything.
    send_word(32'h01020304, 1'b0, 3'd4, 1'b0);
    iRstn = 1'b0;
    @(negedge iClk);
    iRstn = 1'b1;
    got_q.delete();
    done_base = done_cnt;
    repeat (20) @(negedge iClk);
    chk("rst_mid_quiet", {got_q.size() == 0, done_cnt == done_base, oWord_ready}, 3'b110);

    // Single-word table.
    for (int i = 0; i < 7; i++) begin
      start_msg();
      send_word(tbl[i].w, tbl[i].t, tbl[i].n, tbl[i].l);
      if (tbl[i].err) begin
        repeat (3) @(negedge iClk);
        chk($sformatf("tbl%0d_err", i), {oErr, got_q.size() == 0}, 2'b11);
      end else begin
        send_word(32'h0, 1'b1, 3'd0, 1'b1);
        wait_done($sformatf("tbl%0d", i));
        exp_blk(tbl[i].data, 2'b00, 5'(tbl[i].n), 1'b1);
        exp_blk({61'd0, tbl[i].n, 3'd0, 64'h0}, 2'b10, 5'd16, 1'b1);
        compare_blocks($sformatf("tbl%0d", i));
        chk($sformatf("tbl%0d_noerr", i), oErr, 1'b0);
      end
    end

    // Randomized messages with random gaps and backpressure.
    rdy_mode = 2;
    for (int m = 0; m < 20; m++) begin
      wq.delete();
      exp_q.delete();
      gen_seg(1'b0, la);
      gen_seg(1'b1, lp);
      exp_blk({32'd0, 32'(la * 8), 32'd0, 32'(lp * 8)}, 2'b10, 5'd16, 1'b1);
      begin
        blk_t keep[$];
        keep = exp_q;
        start_msg();
        exp_q = keep;
      end
      foreach (wq[j]) begin
        repeat ($urandom_range(0, 2)) @(negedge iClk);
        send_word(wq[j].w, wq[j].t, wq[j].n, wq[j].l);
      end
      wait_done($sformatf("rnd%0d", m));
      compare_blocks($sformatf("rnd%0d", m));
      chk($sformatf("rnd%0d_noerr", m), oErr, 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/gcm_stream_packer.md
GCM_STREAM_PACKER -- requirements
Module: gcm_stream_packer

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-low.
REQ-002 iClk  in  1  rising-edge clock.
REQ-003 iRstn  in  1  synchronous active-low reset.
REQ-004 iStart  in  1  one-cycle pulse; begins (or restarts) a message.
REQ-005 iWord  in  [0:31]  input word; the first byte is bits [0:7].
REQ-006 iWord_valid  in  1  the word is offered.
REQ-007 iWord_type  in  1  0 = AAD, 1 = payload.
REQ-008 iWord_bytes  in  3  valid bytes in the word, 0..4.
REQ-009 iWord_last  in  1  last word of the current segment.
REQ-010 oWord_ready  out  1  a word is accepted when iWord_valid and oWord_ready are both high.
REQ-011 oBlock  out  [0:127]  packed block for the GCM core's iAad/iBlock inputs.
REQ-012 oBlock_type  out  2  00 = AAD, 01 = payload, 10 = length block.
REQ-013 oBlock_bytes  out  5  valid bytes in the block, 1..16.
REQ-014 oBlock_last  out  1  last block of its segment.
REQ-015 oBlock_valid  out  1; iBlock_ready  in  1; a block transfers when both are high.
REQ-016 oDone  out  1  one-cycle pulse after the length block transfers.
REQ-017 oErr  out  1  sticky protocol error; cleared by iStart or reset.

Function
REQ-018 FSM states and transitions:
- IDLE -> AAD on iStart.
- AAD -> DATA when the AAD word carrying iWord_last is accepted.
- DATA -> LEN when the payload word carrying iWord_last is accepted.
- LEN -> IDLE when the length block transfers.
REQ-019 oWord_ready SHALL equal (state is AAD or DATA) AND NOT oBlock_valid; there is no combinational path from iBlock_ready.
REQ-020 Accepted words SHALL pack MSB-first; word k of a block occupies bits [32k : 32k+31].
REQ-021 On the 4th word, or on a last word with a non-empty accumulator or iWord_bytes > 0, the block SHALL load the output register; oBlock_valid goes high the next cycle.
REQ-022 All bytes beyond the valid count SHALL be zero; oBlock_bytes SHALL equal the accumulated byte count.
REQ-023 A segment may be empty: a last word with iWord_bytes = 0 and an empty accumulator SHALL emit no block and only advance the state.
REQ-024 Outputs SHALL hold stable while oBlock_valid is high and iBlock_ready is low.
REQ-025 Byte counters for AAD and payload SHALL be 32 bits each; counter overflow SHALL set oErr.
REQ-026 Length block contents:
- Layout: {AAD_bytes*8 as 64 bits, payload_bytes*8 as 64 bits}, zero-extended.
- Tagging: type 10, bytes 16, last 1.
- Timing: presented the cycle after LEN is entered with the output register free.
REQ-027 oErr SHALL be set, and the word consumed but discarded, on any of:
- iWord_bytes < 4 without iWord_last;
- iWord_bytes = 0 with a non-empty accumulator;
- iWord_type mismatching the current state;
- iWord_bytes > 4.
REQ-028 iStart outside IDLE SHALL abort: discard the accumulator and any pending block, zero the counters, enter AAD. oDone is not pulsed.
REQ-029 iStart and a word in the same cycle: iStart wins and the word is not accepted.

Reset
REQ-030 Reset values: state IDLE, oBlock_valid 0, oWord_ready 0, oDone 0, oErr 0, oBlock all zero, oBlock_type 00, oBlock_bytes 0, oBlock_last 0; counters and accumulator zero.
REQ-031 Reset mid-message SHALL drop all data; no block or oDone follows.

Structure
REQ-032 The shared package gcm_pkg SHALL hold the block-type codes (AAD/PAYLOAD/LEN), the FSM state encodings, and the 128/32 width constants.
REQ-033 The accumulator, word index and zero-padding SHALL be one sub-module, gcm_word_packer; the FSM and counters stay in the top level.

Verification
REQ-034 AAD of 4 words 0x00010203..0x0C0D0E0F with the last flag on word 4, then an empty payload -> one AAD block 0x000102..0F with bytes 16 and last 1, then a length block of 0x0000000000000080 followed by 64 zero bits, then oDone.
REQ-035 Payload 5 words where the last word 0xAABBCCDD has bytes = 2 -> block 2 is 0xAABB followed by 112 zero bits with bytes 2 and last 1; the length block's payload field is 0x90.
REQ-036 iBlock_ready held low for 10 cycles -> oBlock stable, oWord_ready low, no word lost; transfer resumes on release.
REQ-037 Empty AAD plus empty payload -> exactly one block, the all-zero length block, then oDone.
REQ-038 iStart after 2 payload words -> no block emitted, oErr 0; the next message packs correctly.
REQ-039 iWord_bytes = 3 with iWord_last = 0 -> oErr high and stays high until the next iStart.
